// File: rtl/burst_ram_emu.sv
`default_nettype none
// ============================================================================
// Module      : burst_ram_emu
// Description : Burst-access external RAM model with byte write masking,
//               programmable read latency / write recovery, address wrap and
//               optional refresh stalls (macro BURST_RAM_EMU_REFRESH_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module burst_ram_emu #(
    parameter int    DEPTH_BITWIDTH   = 4,
    parameter int    DATA_BITWIDTH    = 64,
    parameter int    BURST_COUNT      = 4,
    parameter int    READ_LATENCY     = 8,
    parameter int    WRITE_RECOVERY   = 0,
`ifdef BURST_RAM_EMU_REFRESH_EN
    parameter int    REFRESH_INTERVAL = 64,
    parameter int    REFRESH_CYCLES   = 4,
`endif
    parameter string DATA_FILE        = ""
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd,
    input  logic                       cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]  addr,
    input  logic [DATA_BITWIDTH-1:0]   wr_data,
    input  logic [DATA_BITWIDTH/8-1:0] data_mask,
    output logic [DATA_BITWIDTH-1:0]   rd_data,
    output logic                       rd_data_valid,
    output logic                       busy
);

    localparam int                  c_WORDS    = 1 << DEPTH_BITWIDTH;
    localparam int                  c_BYTES    = DATA_BITWIDTH / 8;
    localparam logic [31:0]         c_RD_LAST  = 32'(READ_LATENCY - 1);
    localparam logic [31:0]         c_WB_LAST  = 32'(BURST_COUNT - 1);
    localparam logic [31:0]         c_BEATS    = 32'(BURST_COUNT);
    localparam logic [31:0]         c_REC_LAST = 32'(WRITE_RECOVERY - 1);
    localparam logic [DEPTH_BITWIDTH-1:0] c_ADDR_ONE = DEPTH_BITWIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE          = 3'd0,
        S_READ_DELAY    = 3'd1,
        S_READ_BURST    = 3'd2,
        S_WRITE_BURST   = 3'd3,
        S_WRITE_RECOVER = 3'd4
`ifdef BURST_RAM_EMU_REFRESH_EN
        , S_REFRESH     = 3'd5
`endif
    } state_t;

    localparam state_t c_AFTER_WRITE  = (WRITE_RECOVERY == 0) ? S_IDLE : S_WRITE_RECOVER;
    localparam state_t c_AFTER_ACCEPT = (BURST_COUNT > 1) ? S_WRITE_BURST : c_AFTER_WRITE;

    logic [DATA_BITWIDTH-1:0]  r_mem [0:c_WORDS-1];

    state_t                    r_state, w_state_nx;
    logic [31:0]               r_cnt, w_cnt_nx;
    logic [31:0]               r_beat, w_beat_nx;
    logic [DEPTH_BITWIDTH-1:0] r_ptr, w_ptr_nx;
    logic [DATA_BITWIDTH-1:0]  r_rd_data, w_rd_data_nx;
    logic                      r_rd_valid, w_rd_valid_nx;
    logic                      w_we;
    logic [DEPTH_BITWIDTH-1:0] w_waddr;
    logic                      w_ref_pending;

`ifdef BURST_RAM_EMU_REFRESH_EN
    localparam logic [31:0] c_REF_INT_LAST = 32'(REFRESH_INTERVAL - 1);
    localparam logic [31:0] c_REF_LAST     = 32'(REFRESH_CYCLES - 1);

    logic [31:0] r_ref_cnt;
    logic        r_ref_pending;
    logic        w_ref_take;

    // A new request in the same cycle as a take keeps the pending flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cnt     <= '0;
            r_ref_pending <= 1'b0;
        end else if (r_ref_cnt == c_REF_INT_LAST) begin
            r_ref_cnt     <= '0;
            r_ref_pending <= 1'b1;
        end else begin
            r_ref_cnt <= r_ref_cnt + 32'd1;
            if (w_ref_take) begin
                r_ref_pending <= 1'b0;
            end
        end
    end

    assign w_ref_pending = r_ref_pending;
`else
    assign w_ref_pending = 1'b0;
`endif

    assign busy          = (r_state != S_IDLE) | w_ref_pending;
    assign rd_data       = r_rd_data;
    assign rd_data_valid = r_rd_valid;

    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_beat_nx     = r_beat;
        w_ptr_nx      = r_ptr;
        w_rd_data_nx  = r_rd_data;
        w_rd_valid_nx = 1'b0;
        w_we          = 1'b0;
        w_waddr       = r_ptr;
`ifdef BURST_RAM_EMU_REFRESH_EN
        w_ref_take    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
`ifdef BURST_RAM_EMU_REFRESH_EN
                if (r_ref_pending) begin
                    w_state_nx = S_REFRESH;
                    w_cnt_nx   = '0;
                    w_ref_take = 1'b1;
                end else
`endif
                if (cmd_en) begin
                    w_cnt_nx = '0;
                    if (cmd) begin
                        // Beat 0 lands in the accept cycle itself.
                        w_we       = 1'b1;
                        w_waddr    = addr;
                        w_ptr_nx   = addr + c_ADDR_ONE;
                        w_beat_nx  = 32'd1;
                        w_state_nx = c_AFTER_ACCEPT;
                    end else begin
                        w_ptr_nx   = addr;
                        w_beat_nx  = '0;
                        w_state_nx = S_READ_DELAY;
                    end
                end
            end
            S_READ_DELAY: begin
                if (r_cnt == c_RD_LAST) begin
                    w_state_nx    = S_READ_BURST;
                    w_rd_data_nx  = r_mem[r_ptr];
                    w_rd_valid_nx = 1'b1;
                    w_ptr_nx      = r_ptr + c_ADDR_ONE;
                    w_beat_nx     = 32'd1;
                end else begin
                    w_cnt_nx = r_cnt + 32'd1;
                end
            end
            S_READ_BURST: begin
                if (r_beat == c_BEATS) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_rd_data_nx  = r_mem[r_ptr];
                    w_rd_valid_nx = 1'b1;
                    w_ptr_nx      = r_ptr + c_ADDR_ONE;
                    w_beat_nx     = r_beat + 32'd1;
                end
            end
            S_WRITE_BURST: begin
                w_we      = 1'b1;
                w_ptr_nx  = r_ptr + c_ADDR_ONE;
                w_beat_nx = r_beat + 32'd1;
                if (r_beat == c_WB_LAST) begin
                    w_state_nx = c_AFTER_WRITE;
                    w_cnt_nx   = '0;
                end
            end
            S_WRITE_RECOVER: begin
                if (r_cnt == c_REC_LAST) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 32'd1;
                end
            end
`ifdef BURST_RAM_EMU_REFRESH_EN
            S_REFRESH: begin
                if (r_cnt == c_REF_LAST) begin
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 32'd1;
                end
            end
`endif
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_beat     <= '0;
            r_ptr      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_beat     <= w_beat_nx;
            r_ptr      <= w_ptr_nx;
            r_rd_data  <= w_rd_data_nx;
            r_rd_valid <= w_rd_valid_nx;
        end
    end

    // Storage is never cleared by reset; reset only stops further beats.
    always_ff @(posedge clk) begin
        if (!rst && w_we) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (!data_mask[b]) begin
                    r_mem[w_waddr][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_burst_ram_emu.sv
`default_nettype none
// ============================================================================
// Module      : tb_burst_ram_emu
// Description : Self-checking bench for burst_ram_emu with a read-beat
//               scoreboard fed from a reference memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_burst_ram_emu;

    localparam int RL = 8;
    localparam int BC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd;
    logic        cmd_en;
    logic [3:0]  addr;
    logic [63:0] wr_data;
    logic [7:0]  data_mask;
    logic [63:0] rd_data;
    logic        rd_data_valid;
    logic        busy;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] model [16];
    logic [63:0] sbq [$];
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    burst_ram_emu #(
        .DEPTH_BITWIDTH   (4),
        .DATA_BITWIDTH    (64),
        .BURST_COUNT      (BC),
        .READ_LATENCY     (RL),
        .WRITE_RECOVERY   (0),
`ifdef BURST_RAM_EMU_REFRESH_EN
        .REFRESH_INTERVAL (16),
        .REFRESH_CYCLES   (4),
`endif
        .DATA_FILE        ("")
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd           (cmd),
        .cmd_en        (cmd_en),
        .addr          (addr),
        .wr_data       (wr_data),
        .data_mask     (data_mask),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .busy          (busy)
    );

    // Scoreboard: every valid beat must match the oldest expected word.
    always @(negedge clk) begin
        if (rd_data_valid === 1'b1) begin
            n_checks++;
            if (sbq.size() == 0) begin
                $display("FAIL rd_beat unexpected beat got %h exp none", rd_data);
            end else begin
                mon_exp = sbq.pop_front();
                if (rd_data !== mon_exp) begin
                    $display("FAIL rd_beat got %h exp %h", rd_data, mon_exp);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    function automatic void model_write(input logic [3:0] a, input logic [63:0] d,
                                        input logic [7:0] m);
        for (int b = 0; b < 8; b++) begin
            if (!m[b]) model[a][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    function automatic void sb_push_read(input logic [3:0] a);
        for (int k = 0; k < BC; k++) sbq.push_back(model[a + 4'(k)]);
    endfunction

    task automatic wait_idle;
        int k;
        k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy !== 1'b0) begin
            n_checks++;
            $display("FAIL wait_idle busy got %b exp 0", busy);
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [255:0] d,
                            input logic [31:0] m, output logic [3:0] bs);
        wait_idle();
        cmd = 1'b1; addr = a; cmd_en = 1'b1;
        wr_data = d[63:0]; data_mask = m[7:0];
        for (int k = 0; k < BC; k++) model_write(a + 4'(k), d[k*64 +: 64], m[k*8 +: 8]);
        @(posedge clk);
        for (int k = 1; k < BC; k++) begin
            @(negedge clk);
            cmd_en = 1'b0;
            wr_data = d[k*64 +: 64]; data_mask = m[k*8 +: 8];
            bs[k-1] = busy;
            @(posedge clk);
        end
        @(negedge clk);
        bs[BC-1] = busy;
    endtask

    task automatic run_read(input logic [3:0] a, output int first_j, output int nv);
        wait_idle();
        cmd = 1'b0; addr = a; cmd_en = 1'b1;
        sb_push_read(a);
        @(posedge clk);
        #1 cmd_en = 1'b0;
        first_j = -1; nv = 0;
        for (int j = 1; j <= RL + BC + 2; j++) begin
            @(posedge clk); #1;
            if (rd_data_valid === 1'b1) begin
                if (first_j < 0) first_j = j;
                nv++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd = 1'b0; cmd_en = 1'b0; addr = '0; wr_data = '0; data_mask = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({rd_data, rd_data_valid, busy} !== 66'd0) begin
                $display("FAIL reset_idle cycle %0d got data=%h valid=%b busy=%b exp 0/0/0",
                         i, rd_data, rd_data_valid, busy);
            end else n_pass++;
        end
    endtask

    task automatic test_write_read_burst;
        logic [3:0] bs;
        int first_j, nv;
        do_write(4'd2, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                        64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 32'h0, bs);
`ifndef BURST_RAM_EMU_REFRESH_EN
        n_checks++;
        if (bs !== 4'b0111) $display("FAIL write_busy got %b exp 0111", bs);
        else n_pass++;
`endif
        run_read(4'd2, first_j, nv);
        n_checks++;
        if (first_j != RL) $display("FAIL read_latency got %0d exp %0d", first_j, RL);
        else n_pass++;
        n_checks++;
        if (nv != BC) $display("FAIL read_valid_count got %0d exp %0d", nv, BC);
        else n_pass++;
    endtask

    task automatic test_byte_mask;
        logic [3:0] bs;
        int first_j, nv;
        do_write(4'd5, {4{64'hFFFF_FFFF_FFFF_FFFF}}, 32'h0, bs);
        do_write(4'd5, 256'h0, 32'h0F0F_0F0F, bs);
        run_read(4'd5, first_j, nv);
        n_checks++;
        if (nv != BC) $display("FAIL mask_read_count got %0d exp %0d", nv, BC);
        else n_pass++;
        // All-ones mask on beats 0 and 3: those words must stay untouched.
        do_write(4'd5, {4{64'h5555_5555_5555_5555}}, 32'hFF00_00FF, bs);
        run_read(4'd5, first_j, nv);
        n_checks++;
        if (sbq.size() != 0) $display("FAIL mask_sb_drain got %0d exp 0", sbq.size());
        else n_pass++;
    endtask

    task automatic test_wrap;
        logic [3:0] bs;
        int first_j, nv;
        do_write(4'd14, {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                         64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000}, 32'h0, bs);
        run_read(4'd14, first_j, nv);
        run_read(4'd0, first_j, nv);
        n_checks++;
        if (first_j != RL) $display("FAIL wrap_latency got %0d exp %0d", first_j, RL);
        else n_pass++;
        n_checks++;
        if (sbq.size() != 0) $display("FAIL wrap_sb_drain got %0d exp 0", sbq.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [255:0] d;
        int first_j, nv;
        d = {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
             64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000};
        wait_idle();
        for (int k = 0; k < BC; k++) model_write(4'd9 + 4'(k), d[k*64 +: 64], 8'h00);
        sb_push_read(4'd9);
        cmd = 1'b1; addr = 4'd9; wr_data = d[63:0]; data_mask = 8'h00; cmd_en = 1'b1;
        @(posedge clk);
        // Read held on cmd_en during the write burst.
        #1 cmd = 1'b0; wr_data = d[127:64];
        first_j = -1; nv = 0;
        for (int j = 1; j <= 30; j++) begin
            @(posedge clk); #1;
            if (j + 1 < BC) wr_data = d[(j+1)*64 +: 64];
            if (j == BC) cmd_en = 1'b0;
            if (rd_data_valid === 1'b1) begin
                if (first_j < 0) first_j = j;
                nv++;
            end
        end
        cmd_en = 1'b0;
`ifndef BURST_RAM_EMU_REFRESH_EN
        n_checks++;
        if (first_j != BC + RL) $display("FAIL b2b_first_valid got %0d exp %0d", first_j, BC + RL);
        else n_pass++;
`endif
        n_checks++;
        if (nv != BC) $display("FAIL b2b_valid_count got %0d exp %0d", nv, BC);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst;
        int nv, k;
        wait_idle();
        cmd = 1'b0; addr = 4'd2; cmd_en = 1'b1;
        sb_push_read(4'd2);
        @(posedge clk);
        @(negedge clk);
        addr = 4'd14;
        nv = 0; k = 0;
        while (k < 30) begin
            if (rd_data_valid === 1'b1) nv++;
            if (nv == 2) break;
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (nv != 2) $display("FAIL rstmid_second_beat got %0d beats exp 2", nv);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({rd_data_valid, busy} !== 2'b00)
            $display("FAIL rstmid_abort got valid=%b busy=%b exp 0/0", rd_data_valid, busy);
        else n_pass++;
        rst = 1'b0;
        sbq.delete();
        sb_push_read(4'd14);
        @(posedge clk);
        @(negedge clk);
        cmd_en = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL rstmid_held_accept got busy=%b exp 1", busy);
        else n_pass++;
        repeat (RL + BC + 2) @(negedge clk);
        n_checks++;
        if (sbq.size() != 0) $display("FAIL rstmid_sb_drain got %0d exp 0", sbq.size());
        else n_pass++;
    endtask

`ifdef BURST_RAM_EMU_REFRESH_EN
    task automatic test_refresh;
        logic [255:0] d;
        int nb, guard;
        d = {64'hC3C3_0000_1111_0003, 64'hC2C2_0000_1111_0002,
             64'hC1C1_0000_1111_0001, 64'hC0C0_0000_1111_0000};
        @(negedge clk);
        rst = 1'b1; cmd_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (13) @(negedge clk);
        // Accept lands two edges before the first refresh request.
        for (int k = 0; k < BC; k++) model_write(4'd12 + 4'(k), d[k*64 +: 64], 8'h00);
        cmd = 1'b1; addr = 4'd12; wr_data = d[63:0]; data_mask = 8'h00; cmd_en = 1'b1;
        @(posedge clk);
        nb = 0;
        for (int k = 1; k < BC; k++) begin
            @(negedge clk);
            cmd_en = 1'b0;
            wr_data = d[k*64 +: 64];
            if (busy === 1'b1) nb++;
            @(posedge clk);
        end
        @(negedge clk);
        cmd = 1'b0; addr = 4'd12; cmd_en = 1'b1;
        sb_push_read(4'd12);
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            nb++;
            @(negedge clk);
            guard++;
        end
        // 3 burst cycles + 1 pending-in-idle + 4 refresh cycles.
        n_checks++;
        if (nb != 8) $display("FAIL refresh_busy_cycles got %0d exp 8", nb);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        cmd_en = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL refresh_read_accept got busy=%b exp 1", busy);
        else n_pass++;
        repeat (RL + BC + 2) @(negedge clk);
        n_checks++;
        if (sbq.size() != 0) $display("FAIL refresh_sb_drain got %0d exp 0", sbq.size());
        else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read_burst();
        test_byte_mask();
        test_wrap();
        test_back_to_back();
        test_reset_mid_burst();
`ifdef BURST_RAM_EMU_REFRESH_EN
        test_refresh();
`endif
        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
